stopwatch_ctrl: RTL and testbench

Control FSM for the stopwatch. It consumes the periodic 1-cycle tick from the pulse generator, set up for 100 Hz, and two pre-debounced buttons. It sequences start/stop/lap/clear and maintains an MM:SS.CC BCD time count. It drives the display digits and status flags to the display driver.

---
 rtl/stopwatch_pkg.sv | 23 ++
 rtl/stopwatch_if.sv | 14 +
 rtl/bcd_time_counter.sv | 36 +++
 rtl/stopwatch_ctrl.sv | 58 +++++
 tb/tb_stopwatch_ctrl.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types, default limits and BCD helpers for the stopwatch.
// Contents: state_t FSM encoding, bcd_t digit, time_t MM:SS.CC record,
//           to_bcd (binary limit -> 2-digit BCD), bcd_inc (2-digit BCD increment with wrap).
package stopwatch_pkg;
   typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;
   typedef logic [3:0] bcd_t;
   typedef struct packed {
      bcd_t [1:0] min;
      bcd_t [1:0] sec;
      bcd_t [1:0] cs;
   } time_t;
   localparam int MIN_MAX_DEF = 59;
   localparam int SEC_MAX_DEF = 59;
   localparam int CS_MAX_DEF  = 99;
   function automatic logic [7:0] to_bcd(int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction
   // Returns {carry, next}; carry means the field wrapped from lim back to 00.
   function automatic logic [8:0] bcd_inc(logic [7:0] f, logic [7:0] lim);
      if (f == lim) return 9'h100;
      return f[3:0] == 4'd9 ? {1'b0, f[7:4] + 4'd1, 4'd0} : {1'b0, f[7:4], f[3:0] + 4'd1};
   endfunction
endpackage

// File: rtl/stopwatch_if.sv
// stopwatch_if: groups the stopwatch control inputs and display outputs.
// master drives tick/btn_ss/btn_lc and observes the display side; slave is the controller.
// Signals: tick, btn_ss, btn_lc (controls); digits[23:0], running, lap_active, overflow (display).
interface stopwatch_if;
   logic        tick;
   logic        btn_ss;
   logic        btn_lc;
   logic [23:0] digits;
   logic        running;
   logic        lap_active;
   logic        overflow;
   modport master (output tick, btn_ss, btn_lc, input digits, running, lap_active, overflow);
   modport slave  (input tick, btn_ss, btn_lc, output digits, running, lap_active, overflow);
endinterface

// File: rtl/bcd_time_counter.sv
// bcd_time_counter: cascaded MM:SS.CC BCD counter with configurable field limits.
// Ports: clk, rst_n (async active-low), inc (advance one centisecond), clr (zero count),
//        t (registered count), nxt (value t takes on the next edge), wrap (pulse on full rollover).
module bcd_time_counter
   import stopwatch_pkg::*;
#(
   parameter int MIN_MAX = MIN_MAX_DEF,
   parameter int SEC_MAX = SEC_MAX_DEF,
   parameter int CS_MAX  = CS_MAX_DEF
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  inc,
   input  logic  clr,
   output time_t t,
   output time_t nxt,
   output logic  wrap
);
   logic [8:0] cs_i, sec_i, min_i;
   always_comb begin
      cs_i  = bcd_inc(t.cs,  to_bcd(CS_MAX));
      sec_i = bcd_inc(t.sec, to_bcd(SEC_MAX));
      min_i = bcd_inc(t.min, to_bcd(MIN_MAX));
      nxt = t;
      if (inc) begin
         nxt.cs = cs_i[7:0];
         if (cs_i[8]) nxt.sec = sec_i[7:0];
         if (cs_i[8] && sec_i[8]) nxt.min = min_i[7:0];
      end
      if (clr) nxt = '0;
      wrap = inc & cs_i[8] & sec_i[8] & min_i[8];
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) t <= '0;
      else t <= nxt;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/stop/lap/clear FSM driving an MM:SS.CC BCD stopwatch display.
// Ports: clk, rst_n (async active-low), bus (stopwatch_if.slave: tick, btn_ss, btn_lc in;
//        digits, running, lap_active, overflow out).
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int MIN_MAX = MIN_MAX_DEF,
   parameter int SEC_MAX = SEC_MAX_DEF,
   parameter int CS_MAX  = CS_MAX_DEF
) (
   input logic        clk,
   input logic        rst_n,
   stopwatch_if.slave bus
);
   state_t state, state_n;
   time_t  t, t_n, snap;
   logic   ss_q, lc_q, ovf, wrap, take_snap, clr, inc;
   wire    ss_e = bus.btn_ss & ~ss_q;
   wire    lc_e = bus.btn_lc & ~lc_q;
   assign inc = bus.tick & (state == RUN || state == LAP);
   // ss_e is tested first in every state so it wins over a simultaneous lc_e.
   always_comb begin
      state_n   = state;
      take_snap = 1'b0;
      clr       = 1'b0;
      case (state)
         IDLE:  if (ss_e) state_n = RUN;
         RUN:   if (ss_e) state_n = PAUSE;
                else if (lc_e) begin state_n = LAP; take_snap = 1'b1; end
         LAP:   if (ss_e) state_n = PAUSE;
                else if (lc_e) state_n = RUN;
         PAUSE: if (ss_e) state_n = RUN;
                else if (lc_e) begin state_n = IDLE; clr = 1'b1; end
         default: state_n = IDLE;
      endcase
   end
   bcd_time_counter #(.MIN_MAX(MIN_MAX), .SEC_MAX(SEC_MAX), .CS_MAX(CS_MAX)) u_cnt (
      .clk(clk), .rst_n(rst_n), .inc(inc), .clr(clr), .t(t), .nxt(t_n), .wrap(wrap)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         ss_q  <= 1'b0;
         lc_q  <= 1'b0;
         snap  <= '0;
         ovf   <= 1'b0;
      end else begin
         state <= state_n;
         ss_q  <= bus.btn_ss;
         lc_q  <= bus.btn_lc;
         if (take_snap) snap <= t_n;
         ovf <= clr ? 1'b0 : ovf | wrap;
      end
   assign bus.digits     = state == LAP ? snap : t;
   assign bus.running    = state == RUN || state == LAP;
   assign bus.lap_active = state == LAP;
   assign bus.overflow   = ovf;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed checks of stopwatch_ctrl (default limits and a shortened-limit copy).
module tb_stopwatch_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   stopwatch_if a ();
   stopwatch_if b ();
   stopwatch_ctrl u_a (.clk(clk), .rst_n(rst_n), .bus(a));
   stopwatch_ctrl #(.MIN_MAX(0), .SEC_MAX(1), .CS_MAX(9)) u_b (.clk(clk), .rst_n(rst_n), .bus(b));
   always #5 clk = ~clk;
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(string tag, logic [23:0] obs, logic [23:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic ss_a();
      a.btn_ss = 1'b1; cyc(); a.btn_ss = 1'b0; cyc();
   endtask
   task automatic lc_a();
      a.btn_lc = 1'b1; cyc(); a.btn_lc = 1'b0; cyc();
   endtask
   task automatic ticks_a(int n);
      a.tick = 1'b1; repeat (n) cyc(); a.tick = 1'b0;
   endtask
   task automatic ticks_b(int n);
      b.tick = 1'b1; repeat (n) cyc(); b.tick = 1'b0;
   endtask
   initial begin
      a.tick = 0; a.btn_ss = 0; a.btn_lc = 0;
      b.tick = 0; b.btn_ss = 0; b.btn_lc = 0;
      repeat (2) cyc();
      chk("rst_digits", a.digits, 24'h0);
      chk("rst_running", a.running, 0);
      chk("rst_lap", a.lap_active, 0);
      chk("rst_ovf", a.overflow, 0);
      rst_n = 1'b1;
      cyc();
      ticks_a(5);
      chk("idle_tick_ignored", a.digits, 24'h0);
      // start and count 250 ticks
      ss_a();
      chk("start_running", a.running, 1);
      ticks_a(250);
      chk("run_250", a.digits, 24'h000250);
      chk("run_250_running", a.running, 1);
      chk("run_250_ovf", a.overflow, 0);
      ss_a(); lc_a();
      chk("clear_digits", a.digits, 24'h0);
      chk("clear_running", a.running, 0);
      // lap snapshot at 00:01.23
      ss_a();
      ticks_a(123);
      lc_a();
      chk("lap_entry_digits", a.digits, 24'h000123);
      chk("lap_entry_flag", a.lap_active, 1);
      ticks_a(40);
      chk("lap_frozen", a.digits, 24'h000123);
      chk("lap_frozen_flag", a.lap_active, 1);
      a.btn_lc = 1'b1; cyc();
      chk("lap_exit_live", a.digits, 24'h000163);
      chk("lap_exit_flag", a.lap_active, 0);
      a.btn_lc = 1'b0; cyc();
      ss_a(); lc_a();
      // stop coincident with tick at 00:00.09
      ss_a();
      ticks_a(9);
      chk("pre_stop", a.digits, 24'h000009);
      a.btn_ss = 1'b1; a.tick = 1'b1; cyc();
      a.btn_ss = 1'b0; a.tick = 1'b0;
      chk("stop_tick_counted", a.digits, 24'h000010);
      chk("stop_running", a.running, 0);
      cyc();
      ticks_a(5);
      chk("pause_ticks_ignored", a.digits, 24'h000010);
      a.btn_ss = 1'b1; a.tick = 1'b1; cyc();
      a.btn_ss = 1'b0; a.tick = 1'b0;
      chk("resume_tick_dropped", a.digits, 24'h000010);
      chk("resume_running", a.running, 1);
      cyc();
      ss_a(); lc_a();
      chk("clear_after_pause", a.digits, 24'h0);
      chk("clear_after_pause_run", a.running, 0);
      // simultaneous edges in RUN: start/stop wins
      ss_a();
      ticks_a(3);
      a.btn_ss = 1'b1; a.btn_lc = 1'b1; cyc();
      a.btn_ss = 1'b0; a.btn_lc = 1'b0;
      chk("simul_running", a.running, 0);
      chk("simul_lap", a.lap_active, 0);
      chk("simul_digits", a.digits, 24'h000003);
      cyc();
      lc_a();
      chk("simul_then_clear", a.digits, 24'h0);
      // held button yields one edge
      a.btn_ss = 1'b1; repeat (3) cyc(); a.btn_ss = 1'b0; cyc();
      chk("held_single_edge", a.running, 1);
      ss_a(); lc_a();
      // wrap with shortened limits
      b.btn_ss = 1'b1; cyc(); b.btn_ss = 1'b0; cyc();
      ticks_b(19);
      chk("b_pre_wrap", b.digits, 24'h000109);
      chk("b_pre_wrap_ovf", b.overflow, 0);
      ticks_b(1);
      chk("b_wrap_digits", b.digits, 24'h0);
      chk("b_wrap_ovf", b.overflow, 1);
      ticks_b(1);
      chk("b_after_wrap", b.digits, 24'h000001);
      chk("b_ovf_sticky", b.overflow, 1);
      b.btn_ss = 1'b1; cyc(); b.btn_ss = 1'b0; cyc();
      b.btn_lc = 1'b1; cyc(); b.btn_lc = 1'b0; cyc();
      chk("b_clear_ovf", b.overflow, 0);
      chk("b_clear_digits", b.digits, 24'h0);
      // reset mid-LAP with start/stop held
      ss_a();
      ticks_a(500);
      lc_a();
      chk("lap_500", a.digits, 24'h000500);
      a.btn_ss = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("midrst_digits", a.digits, 24'h0);
      chk("midrst_running", a.running, 0);
      chk("midrst_lap", a.lap_active, 0);
      chk("midrst_ovf", a.overflow, 0);
      cyc();
      rst_n = 1'b1;
      cyc();
      chk("post_rst_edge_run", a.running, 1);
      chk("post_rst_digits", a.digits, 24'h0);
      chk("post_rst_lap", a.lap_active, 0);
      a.btn_ss = 1'b0;
      cyc();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
